// File: rtl/conf_pkt_pkg.sv
// Shared types, marker/command codes and 134-bit word builders for the config packet generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conf_pkt_pkg;

    localparam int PKT_W    = 134;
    localparam int PE_IDX_W = 8;

    localparam logic [1:0] MK_META = 2'b11;
    localparam logic [1:0] MK_HEAD = 2'b01;
    localparam logic [1:0] MK_BODY = 2'b00;
    localparam logic [1:0] MK_TAIL = 2'b10;

    localparam logic [7:0] CMD_START = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h03;

    typedef enum logic [3:0] {
        IDLE, GAP, META, HDR, DATA, S_META, S_HDR, S_TAIL, NEXT_PE, DONE
    } state_t;

    function automatic logic [PKT_W-1:0] mk_meta();
        return {MK_META, 4'hf, 96'b0, 4'h1, 12'h0, 16'b0};
    endfunction

    function automatic logic [PKT_W-1:0] mk_hdr(input logic [47:0] dst, input logic [47:0] src,
                                                input logic [15:0] etype, input logic [7:0] pe_id,
                                                input logic [7:0] cmd);
        return {MK_HEAD, 4'hf, dst, src, etype, pe_id, cmd};
    endfunction

    function automatic logic [PKT_W-1:0] mk_body(input logic [1:0] mk, input logic [31:0] data,
                                                 input logic [15:0] addr);
        return {mk, 4'hf, 48'b0, data, 16'b0, addr, 16'b0};
    endfunction

    function automatic logic [PKT_W-1:0] mk_tail();
        return {MK_TAIL, 4'hf, 96'b0, 16'h00fe, 16'b0};
    endfunction

endpackage

// File: rtl/conf_pkt_gen_pe_mask_scan.sv
// Priority encoder: lowest set mask bit at or above 'from', plus a none-left flag.
// Latency: combinational.
// Backpressure: none.
module pe_mask_scan
    import conf_pkt_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        mask,
    input  logic [PE_IDX_W:0]   from,
    output logic [PE_IDX_W-1:0] idx,
    output logic                none
);

    // Walk downward so the lowest qualifying bit is the last one written.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && ((PE_IDX_W + 1)'(i) >= from)) begin
                idx  = PE_IDX_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/conf_pkt_gen.sv
// Streams firmware into per-PE write-config packets (cmd 3) followed by a start packet (cmd 1).
// Latency: o_data is registered, one cycle behind the FSM state; memory data is used 1 cycle after the read.
// Backpressure: i_alf is honoured only between packets (GAP); a packet once started is never stalled.
module conf_pkt_gen
    import conf_pkt_pkg::*;
#(
    parameter int          NUM_PE        = 4,
    parameter int          ADDR_W        = 14,
    parameter int          WORDS_PER_PKT = 64,
    parameter int          GAP_CYCLES    = 4,
    parameter logic [47:0] DST_MAC       = 48'h8988,
    parameter logic [47:0] SRC_MAC       = 48'h1111,
    parameter logic [15:0] ETH_TYPE      = 16'h9005
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [NUM_PE-1:0] i_pe_mask,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_word_cnt,
    output logic              o_mem_rden,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_data_valid,
    output logic [PKT_W-1:0]  o_data,
    input  logic              i_alf,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    // A packet can never usefully be longer than the whole address space.
    localparam logic [CNT_W-1:0] PKT_MAX =
        (WORDS_PER_PKT > (1 << ADDR_W)) ? CNT_MAX : CNT_W'(WORDS_PER_PKT);

    state_t              state;
    logic [NUM_PE-1:0]   mask_q;
    logic [ADDR_W-1:0]   base_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PE_IDX_W-1:0] cur_pe;
    logic [ADDR_W-1:0]   addr;      // address of the next body word to emit
    logic [CNT_W-1:0]    rem;       // words still to send for the current PE
    logic [CNT_W-1:0]    pkt_left;  // words still to emit in the current packet
    logic [15:0]         gap_cnt;   // cycles since the last tail word left

    logic [CNT_W-1:0]    cnt_clamped;
    logic [CNT_W-1:0]    pkt_len;
    logic                gap_ok;
    logic [NUM_PE-1:0]   scan_mask;
    logic [PE_IDX_W:0]   scan_from;
    logic [PE_IDX_W-1:0] scan_idx;
    logic                scan_none;

    assign cnt_clamped = (i_word_cnt > CNT_MAX) ? CNT_MAX : i_word_cnt;
    assign pkt_len     = (rem > PKT_MAX) ? PKT_MAX : rem;
    // The META cycle itself is idle on the bus, so leave GAP one count early.
    assign gap_ok      = (int'(gap_cnt) + 1) >= GAP_CYCLES;
    assign scan_mask   = (state == IDLE) ? i_pe_mask : mask_q;
    assign scan_from   = (state == IDLE) ? '0 : ({1'b0, cur_pe} + (PE_IDX_W + 1)'(1));

    pe_mask_scan #(.N(NUM_PE)) u_scan (
        .mask (scan_mask),
        .from (scan_from),
        .idx  (scan_idx),
        .none (scan_none)
    );

    // Sequencer: state, counters, read pipeline and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mask_q       <= '0;
            base_q       <= '0;
            cnt_q        <= '0;
            cur_pe       <= '0;
            addr         <= '0;
            rem          <= '0;
            pkt_left     <= '0;
            gap_cnt      <= '0;
            o_mem_rden   <= 1'b0;
            o_mem_addr   <= '0;
            o_data_valid <= 1'b0;
            o_data       <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_mem_rden   <= 1'b0;
            o_done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        if (i_pe_mask != '0) begin
                            mask_q  <= i_pe_mask;
                            base_q  <= i_base_addr;
                            cnt_q   <= cnt_clamped;
                            addr    <= i_base_addr;
                            rem     <= cnt_clamped;
                            cur_pe  <= scan_idx;
                            gap_cnt <= '0;
                            o_busy  <= 1'b1;
                            state   <= GAP;
                        end else begin
                            o_done  <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_ok && !i_alf) begin
                        if (rem != '0) begin
                            pkt_left <= pkt_len;
                            state    <= META;
                        end else begin
                            state    <= S_META;
                        end
                    end else if (gap_cnt != 16'hffff) begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                META: begin
                    o_data_valid <= 1'b1;
                    o_data       <= mk_meta();
                    o_mem_rden   <= 1'b1;
                    o_mem_addr   <= addr;
                    state        <= HDR;
                end
                HDR: begin
                    o_data_valid <= 1'b1;
                    o_data       <= mk_hdr(DST_MAC, SRC_MAC, ETH_TYPE, cur_pe, CMD_WRITE);
                    if (pkt_left > CNT_W'(1)) begin
                        o_mem_rden <= 1'b1;
                        o_mem_addr <= o_mem_addr + ADDR_W'(1);
                    end
                    state <= DATA;
                end
                DATA: begin
                    o_data_valid <= 1'b1;
                    addr         <= addr + ADDR_W'(1);
                    rem          <= rem - CNT_W'(1);
                    pkt_left     <= pkt_left - CNT_W'(1);
                    if (pkt_left == CNT_W'(1)) begin
                        o_data  <= mk_body(MK_TAIL, i_mem_rdata, 16'(addr));
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        o_data  <= mk_body(MK_BODY, i_mem_rdata, 16'(addr));
                        // One read is already in flight; fetch ahead only if more remain.
                        if (pkt_left > CNT_W'(2)) begin
                            o_mem_rden <= 1'b1;
                            o_mem_addr <= o_mem_addr + ADDR_W'(1);
                        end
                    end
                end
                S_META: begin
                    o_data_valid <= 1'b1;
                    o_data       <= mk_meta();
                    state        <= S_HDR;
                end
                S_HDR: begin
                    o_data_valid <= 1'b1;
                    o_data       <= mk_hdr(DST_MAC, SRC_MAC, ETH_TYPE, cur_pe, CMD_START);
                    state        <= S_TAIL;
                end
                S_TAIL: begin
                    o_data_valid <= 1'b1;
                    o_data       <= mk_tail();
                    gap_cnt      <= '0;
                    state        <= NEXT_PE;
                end
                NEXT_PE: begin
                    gap_cnt <= gap_cnt + 16'd1;
                    addr    <= base_q;
                    rem     <= cnt_q;
                    if (scan_none) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cur_pe <= scan_idx;
                        state  <= GAP;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
